cms_pix28_cmd_sequencer: RTL

Host-side command initiator for the CMS pixel-28 test firmware command port. It turns one start request into the standard 32-bit command word sequence: status clear, static config 0/1, execute. It then watches the firmware status word until the selected test reports done or error, or a timeout expires. It sits between the PS/AXI register bank and the firmware command decoder, so software can launch a test with one handshake.

---
 rtl/cms_pix28_cmd_sequencer.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/cms_pix28_cmd_sequencer.sv
// cms_pix28_cmd_sequencer: issues CLEAR/CFG0/CFG1/EXEC command words, then polls firmware status.
// Define CMS_PIX28_SEQ_RESET_EN to prefix every run with an RST_FW word.
module cms_pix28_cmd_sequencer #(
    parameter int unsigned TIMEOUT_CYCLES  = 1048576,
    parameter int unsigned CLR_WAIT_CYCLES = 64
) (
    input  logic        fw_axi_clk,
    input  logic        fw_rst,
    input  logic        start,
    input  logic [3:0]  firmware_id,
    input  logic [3:0]  test_sel,
    input  logic [23:0] cfg_static_0,
    input  logic [23:0] cfg_static_1,
    input  logic [23:0] exec_cfg,
    output logic [31:0] cmd_wdata,
    output logic        cmd_wvalid,
    input  logic        cmd_wready,
    input  logic [31:0] fw_status,
    output logic        busy,
    output logic        done,
    output logic [1:0]  result
);
    typedef enum logic [3:0] {
        IDLE, SEL_ERR,
`ifdef CMS_PIX28_SEQ_RESET_EN
        RST_FW,
`endif
        CLEAR, WAIT_CLR, CFG0, CFG1, EXEC, POLL, FIN
    } state_t;
`ifdef CMS_PIX28_SEQ_RESET_EN
    localparam state_t FIRST = RST_FW;
`else
    localparam state_t FIRST = CLEAR;
`endif
    localparam logic [1:0] RES_OK = 2'd0, RES_ERR = 2'd1, RES_TO = 2'd2, RES_SEL = 2'd3;

    state_t      state, state_n;
    logic [1:0]  res_n;
    logic [3:0]  fid, sel, op, st_done;
    logic [23:0] c0, c1, ex, body;
    logic [31:0] cnt;
    logic        st_err, hs, sel_ok;

    function automatic logic onehot(input logic [3:0] x);
        return (x != 4'h0) && ((x & (x - 4'h1)) == 4'h0);
    endfunction

    assign hs     = cmd_wvalid && cmd_wready;
    assign sel_ok = onehot(test_sel) && onehot(firmware_id);
    assign busy   = state != IDLE;
    assign done   = state == FIN;

    always_comb begin
        state_n = state;
        res_n   = result;
        case (state)
            IDLE:     state_n = start ? (sel_ok ? FIRST : SEL_ERR) : IDLE;
            SEL_ERR: begin
                state_n = FIN;
                res_n   = RES_SEL;
            end
`ifdef CMS_PIX28_SEQ_RESET_EN
            RST_FW:   state_n = hs ? CLEAR : RST_FW;
`endif
            CLEAR:    state_n = hs ? WAIT_CLR : CLEAR;
            WAIT_CLR: begin
                if (!st_err && st_done == 4'h0) state_n = CFG0;
                else if (cnt >= CLR_WAIT_CYCLES) begin
                    state_n = FIN;
                    res_n   = RES_TO;
                end
            end
            CFG0:     state_n = hs ? CFG1 : CFG0;
            CFG1:     state_n = hs ? EXEC : CFG1;
            EXEC:     state_n = hs ? POLL : EXEC;
            POLL: begin
                // error outranks done when both appear in the same sample
                if (st_err || |(st_done & sel) || cnt >= TIMEOUT_CYCLES - 1) begin
                    state_n = FIN;
                    res_n   = st_err ? RES_ERR : |(st_done & sel) ? RES_OK : RES_TO;
                end
            end
            default:  state_n = IDLE;
        endcase
    end

    always_comb begin
        cmd_wvalid = 1'b1;
        op         = 4'h0;
        body       = 24'h0;
        case (state)
`ifdef CMS_PIX28_SEQ_RESET_EN
            RST_FW: op = 4'h1;
`endif
            CLEAR:  op = 4'hE;
            CFG0: begin
                op   = 4'h2;
                body = c0;
            end
            CFG1: begin
                op   = 4'h4;
                body = c1;
            end
            EXEC: begin
                op   = 4'hF;
                body = ex;
            end
            default: cmd_wvalid = 1'b0;
        endcase
    end

    assign cmd_wdata = cmd_wvalid ? {fid, op, body} : 32'h0;

    always_ff @(posedge fw_axi_clk) begin
        if (fw_rst) begin
            state   <= IDLE;
            result  <= RES_OK;
            cnt     <= 32'h0;
            st_err  <= 1'b0;
            st_done <= 4'h0;
            fid     <= 4'h0;
            sel     <= 4'h0;
            c0      <= 24'h0;
            c1      <= 24'h0;
            ex      <= 24'h0;
        end else begin
            state   <= state_n;
            result  <= res_n;
            st_err  <= fw_status[31];
            st_done <= fw_status[17:14];
            cnt     <= (state_n != state) ? 32'h0 : (&cnt ? cnt : cnt + 32'd1);
            if (state == IDLE && start) begin
                fid <= firmware_id;
                sel <= test_sel;
                c0  <= cfg_static_0;
                c1  <= cfg_static_1;
                ex  <= exec_cfg;
            end
        end
    end
endmodule
